// File: rtl/wb_uart_master_if.sv
// Host command/response channel plus the Wishbone-style strobe/ack port to the UART.
// master = the bridge itself; slave = the surrounding host and UART.
interface wb_uart_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data_out;
    logic [DATA_W-1:0] wb_data_in;
    logic              wb_we;
    logic              wb_stb;
    logic              wb_ack;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data, wb_data_in, wb_ack,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               wb_addr, wb_data_out, wb_we, wb_stb
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_data, wb_data_in, wb_ack,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               wb_addr, wb_data_out, wb_we, wb_stb
    );
endinterface

// File: rtl/wb_uart_master.sv
// Host command -> one four-phase strobe/ack UART access; rsp_valid 4 edges after accept with a 1-cycle-ack slave.
// One command in flight, no response backpressure; WB_UART_MASTER_TIMEOUT_EN enables the strobe timeout.
module wb_uart_master #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic             wb_clk,
    input  logic             reset,
    wb_uart_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, STROBE, RELEASE, RESP} state_t;

    if (TIMEOUT < 2 || TIMEOUT > (1 << TIMEOUT_W) - 1) begin : g_bad_timeout
        $error("wb_uart_master: TIMEOUT must be >= 2 and fit in TIMEOUT_W bits");
    end

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;
    logic              wb_stb_q, wb_stb_d;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_out_q, wb_data_out_d;
    logic              accept;
    logic              timeout_hit;

    assign accept = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;

`ifdef WB_UART_MASTER_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 rsp_err_q, rsp_err_d;

    assign timeout_hit = (cnt_q == CNT_LAST);

    // Ack is tested before the counter, so an ack landing on the last count wins.
    always_comb begin
        cnt_d     = cnt_q;
        err_d     = err_q;
        rsp_err_d = 1'b0;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == STROBE && !bus.wb_ack && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == STROBE && !bus.wb_ack && timeout_hit) begin
            err_d = 1'b1;
        end else if (state_q == RESP) begin
            err_d = 1'b0;
        end
        if (state_d == RESP) begin
            rsp_err_d = err_q;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (reset) begin
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge wb_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
            wb_stb_q      <= 1'b0;
            wb_we_q       <= 1'b1;
            wb_addr_q     <= '0;
            wb_data_out_q <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            busy_q        <= busy_d;
            wb_stb_q      <= wb_stb_d;
            wb_we_q       <= wb_we_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_out_q <= wb_data_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = STROBE;
            STROBE:  if (bus.wb_ack || timeout_hit) state_d = RELEASE;
            RELEASE: if (!bus.wb_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered versions of where the FSM is heading next.
    always_comb begin
        cmd_ready_d   = (state_d == IDLE) && !bus.wb_ack;
        busy_d        = (state_d != IDLE);
        wb_stb_d      = (state_d == STROBE);
        rsp_valid_d   = (state_d == RESP);
        rsp_data_d    = rsp_data_q;
        wb_we_d       = wb_we_q;
        wb_addr_d     = wb_addr_q;
        wb_data_out_d = wb_data_out_q;
        if (accept) begin
            wb_addr_d     = bus.cmd_addr;
            wb_data_out_d = bus.cmd_data;
            wb_we_d       = ~bus.cmd_we;
        end
        if (state_q == STROBE && bus.wb_ack && wb_we_q) begin
            rsp_data_d = bus.wb_data_in;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.busy        = busy_q;
    assign bus.wb_stb      = wb_stb_q;
    assign bus.wb_we       = wb_we_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data_out = wb_data_out_q;
endmodule

// File: tb/tb_wb_uart_master.sv
// Directed bench for wb_uart_master with a one-cycle-ack UART model and a manual ack override.
module tb_wb_uart_master;
    logic       wb_clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_we;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [7:0] rd_val;
    logic       uart_en;
    logic       man_ack;
    logic       uart_ack_q = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    int         o_stb, o_rsp_cnt, o_rsp_idx;
    logic [7:0] o_rdat, o_dout0;
    logic       o_rerr, o_we0;
    logic [1:0] o_addr0;

    wb_uart_master_if #(.ADDR_W(2), .DATA_W(8)) bus ();

    wb_uart_master #(.ADDR_W(2), .DATA_W(8), .TIMEOUT(4), .TIMEOUT_W(8)) dut (
        .wb_clk (wb_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 wb_clk = ~wb_clk;

    always @(posedge wb_clk) uart_ack_q <= uart_en && bus.wb_stb;

    assign bus.cmd_valid  = cmd_valid;
    assign bus.cmd_we     = cmd_we;
    assign bus.cmd_addr   = cmd_addr;
    assign bus.cmd_data   = cmd_data;
    assign bus.wb_data_in = rd_val;
    assign bus.wb_ack     = uart_ack_q | man_ack;

    task automatic tick();
        @(negedge wb_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Index 0 is the sample right after the accepting edge.
    task automatic observe(input int ncyc, input int ack_at);
        o_stb = 0; o_rsp_cnt = 0; o_rsp_idx = -1; o_rdat = 'x; o_rerr = 1'bx;
        o_we0 = bus.wb_we; o_addr0 = bus.wb_addr; o_dout0 = bus.wb_data_out;
        for (int i = 0; i < ncyc; i++) begin
            if (bus.wb_stb) o_stb++;
            if (bus.rsp_valid) begin
                if (o_rsp_cnt == 0) begin
                    o_rsp_idx = i; o_rdat = bus.rsp_data; o_rerr = bus.rsp_err;
                end
                o_rsp_cnt++;
            end
            man_ack = (i == ack_at);
            tick();
        end
        man_ack = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && bus.cmd_ready !== 1'b1; i++) tick();
        chk("accept_wait", bus.cmd_ready, 1);
    endtask

    task automatic run_txn(input logic we, input logic [1:0] addr, input logic [7:0] data,
                           input int ncyc, input int ack_at);
        cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        wait_ready();
        tick();
        cmd_valid = 1'b0;
        observe(ncyc, ack_at);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_rdy, second_stb, rsp1, rsp2, ovl, gap;
        logic       low, we2;
        logic [1:0] addr2;
        logic [7:0] rd1, rd2;

        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
        rd_val = '0; uart_en = 1'b1; man_ack = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_stb", bus.wb_stb, 0);
        chk("rst_we", bus.wb_we, 1);
        chk("rst_addr", bus.wb_addr, 0);
        chk("rst_dout", bus.wb_data_out, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", bus.cmd_ready, 1);

        // Write 0x41 to TX
        run_txn(1'b1, 2'd0, 8'h41, 8, -1);
        chk("wr_we", o_we0, 0);
        chk("wr_addr", o_addr0, 0);
        chk("wr_dout", o_dout0, 8'h41);
        chk("wr_stb_cycles", o_stb, 2);
        chk("wr_rsp_idx", o_rsp_idx, 4);
        chk("wr_rsp_cnt", o_rsp_cnt, 1);
        chk("wr_rsp_err", o_rerr, 0);
        chk("wr_rsp_data", o_rdat, 8'h00);
        chk("wr_idle_busy", bus.busy, 0);
        chk("wr_idle_ready", bus.cmd_ready, 1);

        // Read RX
        rd_val = 8'h5A;
        run_txn(1'b0, 2'd1, 8'h00, 8, -1);
        chk("rd_we", o_we0, 1);
        chk("rd_addr", o_addr0, 1);
        chk("rd_data", o_rdat, 8'h5A);
        chk("rd_rsp_cnt", o_rsp_cnt, 1);
        chk("rd_rsp_idx", o_rsp_idx, 4);
        chk("rd_data_held", bus.rsp_data, 8'h5A);

        // Divider write with a read queued behind it
        rd_val = 8'h33;
        cmd_we = 1'b1; cmd_addr = 2'd2; cmd_data = 8'h0C; cmd_valid = 1'b1;
        wait_ready();
        tick();
        cmd_we = 1'b0; cmd_addr = 2'd1; cmd_data = 8'hFF;
        first_rdy = -1; second_stb = -1; rsp1 = -1; rsp2 = -1; ovl = 0; gap = 0;
        low = 1'b0; we2 = 1'bx; addr2 = 'x; rd1 = 'x; rd2 = 'x;
        for (int i = 0; i < 16; i++) begin
            if (bus.cmd_ready && first_rdy < 0) first_rdy = i;
            if (!bus.wb_stb) low = 1'b1;
            else if (low && second_stb < 0) begin
                second_stb = i; we2 = bus.wb_we; addr2 = bus.wb_addr;
            end
            if (bus.rsp_valid) begin
                if (rsp1 < 0) begin rsp1 = i; rd1 = bus.rsp_data; end
                else begin rsp2 = i; rd2 = bus.rsp_data; end
            end
            if (bus.rsp_valid && bus.wb_stb) ovl++;
            if (i >= 2 && i <= 5 && bus.wb_stb) gap++;
            if (first_rdy >= 0 && i > first_rdy) cmd_valid = 1'b0;
            tick();
        end
        cmd_valid = 1'b0;
        chk("b2b_rsp1_idx", rsp1, 4);
        chk("b2b_rsp1_data", rd1, 8'h5A);
        chk("b2b_ready_idx", first_rdy, 5);
        chk("b2b_stb2_idx", second_stb, 6);
        chk("b2b_stb2_we", we2, 1);
        chk("b2b_stb2_addr", addr2, 1);
        chk("b2b_rsp2_idx", rsp2, 10);
        chk("b2b_rsp2_data", rd2, 8'h33);
        chk("b2b_overlap", ovl, 0);
        chk("b2b_gap_stb", gap, 0);

        // Stale ack at idle blocks acceptance
        rd_val = 8'h77;
        man_ack = 1'b1;
        tick();
        cmd_we = 1'b0; cmd_addr = 2'd3; cmd_valid = 1'b1;
        chk("stale_rdy_1", bus.cmd_ready, 0);
        tick();
        chk("stale_rdy_2", bus.cmd_ready, 0);
        tick();
        chk("stale_rdy_3", bus.cmd_ready, 0);
        man_ack = 1'b0;
        tick();
        chk("stale_rdy_back", bus.cmd_ready, 1);
        chk("stale_no_stb", bus.wb_stb, 0);
        tick();
        cmd_valid = 1'b0;
        observe(8, -1);
        chk("stale_acc_addr", o_addr0, 3);
        chk("stale_acc_stb", o_stb, 2);
        chk("stale_rsp_idx", o_rsp_idx, 4);
        chk("stale_rsp_data", o_rdat, 8'h77);

        // Ack arrives on the last timeout count: ack wins
        uart_en = 1'b0; rd_val = 8'h99;
        run_txn(1'b0, 2'd2, 8'h00, 10, 3);
        chk("late_ack_stb", o_stb, 4);
        chk("late_ack_rsp_idx", o_rsp_idx, 5);
        chk("late_ack_err", o_rerr, 0);
        chk("late_ack_data", o_rdat, 8'h99);

`ifdef WB_UART_MASTER_TIMEOUT_EN
        run_txn(1'b0, 2'd1, 8'h00, 10, -1);
        chk("tmo_stb", o_stb, 4);
        chk("tmo_rsp_idx", o_rsp_idx, 5);
        chk("tmo_rsp_cnt", o_rsp_cnt, 1);
        chk("tmo_err", o_rerr, 1);
        chk("tmo_data_kept", o_rdat, 8'h99);
        uart_en = 1'b1;
        run_txn(1'b1, 2'd0, 8'h10, 8, -1);
        chk("tmo_recover_err", o_rerr, 0);
        chk("tmo_recover_idx", o_rsp_idx, 4);
`else
        run_txn(1'b0, 2'd1, 8'h00, 1000, -1);
        chk("noto_stb", o_stb, 1000);
        chk("noto_rsp_cnt", o_rsp_cnt, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        uart_en = 1'b1;
        tick();
`endif

        // Reset while strobing
        uart_en = 1'b0;
        cmd_we = 1'b1; cmd_addr = 2'd0; cmd_data = 8'hAA; cmd_valid = 1'b1;
        wait_ready();
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_busy", bus.busy, 1);
        chk("mid_stb", bus.wb_stb, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_stb", bus.wb_stb, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rsp", bus.rsp_valid, 0);
        chk("mid_rst_we", bus.wb_we, 1);
        reset = 1'b0;
        uart_en = 1'b1;
        observe(4, -1);
        chk("mid_no_rsp", o_rsp_cnt, 0);
        rd_val = 8'h3C;
        run_txn(1'b0, 2'd1, 8'h00, 8, -1);
        chk("post_rst_idx", o_rsp_idx, 4);
        chk("post_rst_cnt", o_rsp_cnt, 1);
        chk("post_rst_data", o_rdat, 8'h3C);
        chk("post_rst_err", o_rerr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
